// File: rtl/key_note_encoder_pkg.sv
// ---------------------------------------------------------------------------
// key_note_encoder_pkg
// Purpose : note codes and debounce FSM state encodings shared by the key
//           encoder and the song-tracking FSMs, plus the key-to-note
//           priority encoder.
// Contents: NOTE_* codes (none=0, C4..C5 = 1..8), state_t (STABLE/SETTLE),
//           key_to_note() priority encoder.
// ---------------------------------------------------------------------------
package key_note_encoder_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;
  localparam logic [3:0] NOTE_A    = 4'd6;
  localparam logic [3:0] NOTE_B    = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  // Lowest-index set key wins; key bit i maps to note code i+1.
  // Scanning from the top down lets the lowest set bit overwrite last.
  function automatic logic [3:0] key_to_note(input logic [7:0] keys);
    logic [3:0] code;
    code = NOTE_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (keys[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_note_encoder_key_sync2.sv
// ---------------------------------------------------------------------------
// key_sync2
// Purpose : two-flop synchroniser for asynchronous level inputs.
// Ports   : i_clk  - clock
//           i_srst - synchronous active-high reset (clears both stages)
//           i_d    - asynchronous input bus [W-1:0]
//           o_q    - synchronised output bus [W-1:0]
// ---------------------------------------------------------------------------
module key_sync2 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // First stage may go metastable: nothing reads it except the second stage.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_note_encoder.sv
// ---------------------------------------------------------------------------
// key_note_encoder
// Purpose : turns 8 raw piano keys into a debounced, registered 4-bit note
//           code (0 = no key), with a one-cycle pulse on each new note.
// Ports   : CLK     - system clock (rising edge)
//           RESET   - synchronous active-high reset
//           key     - raw async keys [7:0], [0]=C4 ... [7]=C5, active-high
//           note    - debounced note code, registered
//           note_on - one-cycle pulse with a change to a non-none note
// ---------------------------------------------------------------------------
module key_note_encoder
  import key_note_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] key,
  output logic [3:0] note,
  output logic       note_on
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0]       w_key_s;
  logic [3:0]       w_cand;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pend;
  logic [3:0]       r_note;
  logic             r_note_on;

  key_sync2 #(
    .W (8)
  ) u_sync (
    .i_clk  (CLK),
    .i_srst (RESET),
    .i_d    (key),
    .o_q    (w_key_s)
  );

  assign w_cand = key_to_note(w_key_s);

  // r_cnt counts consecutive edges on which w_cand has matched r_pend; the
  // edge that enters SETTLE counts as the first one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_pend    <= NOTE_NONE;
      r_note    <= NOTE_NONE;
      r_note_on <= 1'b0;
    end else begin
      r_note_on <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_cand != r_note) begin
            r_pend  <= w_cand;
            r_cnt   <= CNT_ONE;
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_cand != r_pend) begin
            if (w_cand == r_note) begin
              // Bounced back to the current note: nothing to report.
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end else begin
              r_pend <= w_cand;
              r_cnt  <= CNT_ONE;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_note    <= r_pend;
            r_note_on <= (r_pend != NOTE_NONE);
            r_cnt     <= '0;
            r_state   <= ST_STABLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_STABLE;
        end
      endcase
    end
  end

  assign note    = r_note;
  assign note_on = r_note_on;

endmodule

// File: tb/tb_key_note_encoder.sv
// ---------------------------------------------------------------------------
// tb_key_note_encoder
// Self-checking bench for key_note_encoder with DEBOUNCE_CYCLES = 4.
// Reference model: keys are delayed two edges, mapped to a note by a plain
// lowest-set-bit scan, and the note is accepted once that candidate has held
// the same value for D consecutive edges while differing from the note.
// ---------------------------------------------------------------------------
module tb_key_note_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic [3:0] note;
  logic       note_on;

  int n_cmp = 0;
  int n_bad = 0;

  key_note_encoder #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .key     (key),
    .note    (note),
    .note_on (note_on)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_s1, m_s2;
  logic [3:0] m_note, m_prev;
  logic       m_on;
  int         m_run;

  function automatic logic [3:0] ref_code(input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      if (k[i]) return 4'(i + 1);
    end
    return 4'd0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] c;
    int         run_n;
    if (rst) begin
      m_s1   <= 8'h00;
      m_s2   <= 8'h00;
      m_note <= 4'd0;
      m_on   <= 1'b0;
      m_prev <= 4'd0;
      m_run  <= 0;
    end else begin
      c     = ref_code(m_s2);
      run_n = (c == m_prev) ? m_run + 1 : 1;
      m_prev <= c;
      m_run  <= run_n;
      m_on   <= 1'b0;
      if (c != m_note && run_n >= D) begin
        m_note <= c;
        m_on   <= (c != 4'd0);
      end
      m_s2 <= m_s1;
      m_s1 <= key;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    key = 8'hFF;
    for (int e = 0; e < 2; e++) begin
      tick();
      n_cmp++;
      if (note !== 4'd0 || note_on !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold e=%0d note=%0d note_on=%0b required 0/0", e, note, note_on);
      end
    end
    rst = 1'b0;
    key = 8'h00;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_cmp++;
      if (note !== 4'd0 || note_on !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle e=%0d note=%0d note_on=%0b required 0/0", e, note, note_on);
      end
    end
    $display("test_reset: note=%0d note_on=%0b", note, note_on);
  endtask

  task automatic test_clean_press();
    int chg = -1;
    int pulses = 0;
    key = 8'h04;  // first sampled at edge 1
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_cmp++;
      if (note !== m_note || note_on !== m_on) begin
        n_bad++;
        $display("FAIL press_cycle e=%0d note=%0d exp %0d note_on=%0b exp %0b", e, note, m_note, note_on, m_on);
      end
      if (note_on === 1'b1) pulses++;
      if (chg < 0 && note === 4'd3) chg = e;
    end
    n_cmp++;
    if (chg !== 1 + D + 1) begin
      n_bad++;
      $display("FAIL press_latency edge=%0d required %0d", chg, 1 + D + 1);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL press_pulses got %0d required 1", pulses);
    end
    $display("test_clean_press: note=%0d at edge %0d, pulses=%0d", note, chg, pulses);
  endtask

  task automatic test_release();
    int chg = -1;
    int pulses = 0;
    key = 8'h00;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_cmp++;
      if (note !== m_note || note_on !== m_on) begin
        n_bad++;
        $display("FAIL release_cycle e=%0d note=%0d exp %0d note_on=%0b exp %0b", e, note, m_note, note_on, m_on);
      end
      if (note_on === 1'b1) pulses++;
      if (chg < 0 && note === 4'd0) chg = e;
    end
    n_cmp++;
    if (chg !== 1 + D + 1) begin
      n_bad++;
      $display("FAIL release_latency edge=%0d required %0d", chg, 1 + D + 1);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL release_pulses got %0d required 0", pulses);
    end
    $display("test_release: note=%0d at edge %0d, pulses=%0d", note, chg, pulses);
  endtask

  task automatic test_bounce();
    logic [7:0] pat [3] = '{8'h04, 8'h00, 8'h04};
    int pulses = 0;
    for (int e = 0; e < 15; e++) begin
      key = (e < 3) ? pat[e] : 8'h04;
      tick();
      n_cmp++;
      if (note !== m_note || note_on !== m_on) begin
        n_bad++;
        $display("FAIL bounce_cycle e=%0d note=%0d exp %0d note_on=%0b exp %0b", e, note, m_note, note_on, m_on);
      end
      if (note_on === 1'b1) pulses++;
    end
    n_cmp++;
    if (note !== 4'd3 || pulses !== 1) begin
      n_bad++;
      $display("FAIL bounce_result note=%0d pulses=%0d required 3/1", note, pulses);
    end
    $display("test_bounce: note=%0d pulses=%0d", note, pulses);
  endtask

  task automatic test_note_to_note();
    logic [7:0] keys [2] = '{8'h12, 8'h10};
    logic [3:0] want [2] = '{4'd2, 4'd5};
    for (int p = 0; p < 2; p++) begin
      int pulses = 0;
      int zeros = 0;
      key = keys[p];
      for (int e = 0; e < 12; e++) begin
        tick();
        n_cmp++;
        if (note !== m_note || note_on !== m_on) begin
          n_bad++;
          $display("FAIL n2n_cycle p=%0d e=%0d note=%0d exp %0d note_on=%0b exp %0b", p, e, note, m_note, note_on, m_on);
        end
        if (note_on === 1'b1) pulses++;
        if (note === 4'd0) zeros++;
      end
      n_cmp++;
      if (note !== want[p] || pulses !== 1 || zeros !== 0) begin
        n_bad++;
        $display("FAIL n2n_result p=%0d note=%0d pulses=%0d zeros=%0d required %0d/1/0", p, note, pulses, zeros, want[p]);
      end
      $display("test_note_to_note: key=%h note=%0d pulses=%0d", keys[p], note, pulses);
    end
  endtask

  task automatic test_reset_mid_settle();
    int chg = -1;
    key = 8'h00;
    for (int e = 0; e < 10; e++) tick();
    n_cmp++;
    if (note !== 4'd0) begin
      n_bad++;
      $display("FAIL rms_pre note=%0d required 0", note);
    end
    key = 8'h04;  // first sampled at edge 1
    for (int e = 1; e <= 14; e++) begin
      rst = (e == 3);
      tick();
      n_cmp++;
      if (note !== m_note || note_on !== m_on) begin
        n_bad++;
        $display("FAIL rms_cycle e=%0d note=%0d exp %0d note_on=%0b exp %0b", e, note, m_note, note_on, m_on);
      end
      if (chg < 0 && note === 4'd3) chg = e;
    end
    rst = 1'b0;
    // Reset at edge 3; key sampled afresh at edge 4, note five edges later.
    n_cmp++;
    if (chg !== 4 + D + 1) begin
      n_bad++;
      $display("FAIL rms_latency edge=%0d required %0d", chg, 4 + D + 1);
    end
    $display("test_reset_mid_settle: note=%0d at edge %0d", note, chg);
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      int hold = $urandom_range(1, 7);
      int sel = $urandom_range(0, 3);
      int bad0 = n_bad;
      logic [7:0] k;
      case (sel)
        0:       k = 8'h00;
        1, 2:    k = 8'h01 << $urandom_range(0, 7);
        default: k = 8'($urandom);
      endcase
      key = k;
      for (int e = 0; e < hold; e++) begin
        rst = (e == 0) && ($urandom_range(0, 19) == 0);
        tick();
        n_cmp++;
        if (note !== m_note || note_on !== m_on) begin
          n_bad++;
          $display("FAIL rand_cycle t=%0d e=%0d note=%0d exp %0d note_on=%0b exp %0b", t, e, note, m_note, note_on, m_on);
        end
      end
      rst = 1'b0;
      $display("test_random: t=%0d key=%h hold=%0d note=%0d errs=%0d", t, k, hold, note, n_bad - bad0);
    end
  endtask

  initial begin
    rst = 1'b1;
    key = 8'h00;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_note_to_note();
    test_reset_mid_settle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
